rotation_recombine: RTL
=======================

Name: rotation_recombine

Overview:
- Inverse of the CORDIC rotation/compare chain.
- Takes the per-stage decision bits (1 = stage subtracted its constant) and the final residue, and re-adds the constants iteratively to rebuild the original data word.
- Uses one shared adder and a STAGES-cycle loop. Constants come from an external ROM addressed by comp_idx.
- Sits at the output of the decomposition pipeline, for reconstruction and round-trip self-check.

Parameters:
- DSIZE, 16, data/constant width.
- STAGES, 16, number of decision bits/constants, at least 1.
- IDXW, 4, constant-index width; must satisfy 2^IDXW >= STAGES.

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept; high only in IDLE.
- in_rel  in  STAGES  decision bits; bit i = 1 means stage i subtracted comp[i].
- in_rem  in  DSIZE  residue after the last stage.
- comp_idx  out  IDXW  ROM address, registered.
- comp  in  DSIZE  ROM data for comp_idx, valid combinationally in the same cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- odata  out  DSIZE  reconstructed value, modulo 2^DSIZE.
- ovf  out  1  sticky carry-out seen during reconstruction.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst high at a clock edge) sets:
  - state = IDLE, acc = 0, bits = 0, idx = 0;
  - out_valid = 0, odata = 0, ovf = 0, comp_idx = 0, busy = 0;
  - in_ready = 1 from the first post-reset cycle.
- Reset wins over all other events and aborts RUN or DONE immediately. No partial result is emitted.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - Accept when in_valid & in_ready: acc <= in_rem, bits <= in_rel, idx <= STAGES-1, ovf <= 0; go to RUN.
- RUN, one stage per clock, highest index first:
  - comp_idx = idx.
  - acc <= acc + (bits[idx] ? comp : 0), truncated to DSIZE.
  - ovf <= ovf | carry-out of that add.
  - If idx == 0, go to DONE; else idx <= idx-1.
  - Exactly STAGES clocks in RUN.
- DONE:
  - out_valid = 1, odata = acc, both held stable until out_ready = 1.
  - On out_valid & out_ready, go to IDLE and clear out_valid.
  - odata and ovf keep their last values until the next accept.
- Latency: out_valid rises STAGES clocks after the accept edge.
- Throughput: one word per STAGES+2 clocks at best (accept, STAGES RUN cycles, handshake). No overlap of input and output.
- in_valid outside IDLE is ignored; in_ready = 0 there. in_rel and in_rem are sampled only at the accept edge.
- With all in_rel bits = 0, the result is odata = in_rem and ovf = 0 after STAGES cycles. The loop is never shortened.
- With STAGES = 1, RUN lasts one cycle.
- The addition order is fixed (STAGES-1 down to 0). Sticky ovf guarantees the same flag regardless of wrap position.

Test Plan (DSIZE=16, STAGES=4, IDXW=2, ROM comp[0..3] = 0x0800, 0x0400, 0x0200, 0x0100):
- Basic reconstruction:
  - Stimulus: in_rel=4'b1011, in_rem=0x0010, out_ready=1.
  - Required: comp_idx sequence 3, 2, 1, 0 on successive RUN cycles; out_valid exactly 4 clocks after accept; odata=0x0D10; ovf=0.
- Wrap / overflow:
  - Stimulus: in_rel=4'b0001, in_rem=0xFF00.
  - Required: odata=0x0700, ovf=1. Next job in_rel=0, in_rem=0x1234 gives odata=0x1234, ovf=0.
- Back-pressure:
  - Stimulus: out_ready held low 5 cycles in DONE.
  - Required: out_valid, odata, ovf stable throughout; in_ready=0; in_valid pulses ignored; IDLE on the cycle after out_ready=1.
- Round trip with the forward compare chain:
  - Stimulus: pass 0x0D10 through 4 compare/subtract stages using the same constants, giving bits 1011 and residue 0x0010; feed both to this block.
  - Required: odata=0x0D10.
- Reset mid-RUN:
  - Stimulus: assert rst for 1 cycle on the 2nd RUN cycle.
  - Required: next cycle out_valid=0, odata=0, ovf=0, busy=0, in_ready=1, comp_idx=0. A fresh job then completes normally.
- All-zero bits:
  - Stimulus: in_rel=0, in_rem=0xABCD.
  - Required: still 4 RUN cycles; odata=0xABCD; ovf=0.

Source files
------------

// File: rtl/rotation_recombine.sv
// Rebuilds a data word from CORDIC decision bits and residue by re-adding the
// stage constants, highest stage first, through one shared adder.
module rotation_recombine #(
    parameter int DSIZE  = 16,
    parameter int STAGES = 16,
    parameter int IDXW   = 4
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [STAGES-1:0] in_rel,
    input  logic [DSIZE-1:0]  in_rem,
    output logic [IDXW-1:0]   comp_idx,
    input  logic [DSIZE-1:0]  comp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DSIZE-1:0]  odata,
    output logic              ovf,
    output logic              busy
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(STAGES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [DSIZE-1:0]   acc;
    logic [STAGES-1:0]  bits;
    logic [IDXW-1:0]    idx;
    logic               ovf_q;
    logic [DSIZE-1:0]   addend;
    logic [DSIZE:0]     sum;
    logic               accept;

    // idx is a register, so driving the ROM address from it keeps comp_idx registered
    assign comp_idx  = idx;
    assign odata     = acc;
    assign ovf       = ovf_q;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        addend    = bits[idx] ? comp : '0;
        sum       = {1'b0, acc} + {1'b0, addend};
        accept    = in_valid && (state == IDLE);
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (idx == '0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            bits  <= '0;
            idx   <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    acc   <= in_rem;
                    bits  <= in_rel;
                    idx   <= LAST_IDX;
                    ovf_q <= 1'b0;
                end
                RUN: begin
                    acc   <= sum[DSIZE-1:0];
                    ovf_q <= ovf_q | sum[DSIZE];
                    if (idx != '0) idx <= idx - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
